ccip_req_mux: RTL

Parametrised N-channel CCI-P request multiplexer with response demultiplexer. It sits between the CCI-P boundary (after any clock-crossing shim) and several independent AFU engines. Each engine gets a private buffered request port with almost-full backpressure. Requests are merged round-robin onto one upstream port and tagged with the channel ID in the high mdata bits. Responses are steered back to the issuing channel by that tag.

---
 rtl/ccip_req_mux_if.sv | 39 +++
 rtl/ccip_req_mux.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ccip_req_mux_if.sv
// Bundle of the client request ports, the merged upstream request port and the
// response path of ccip_req_mux. The mux sits on the slave side.
interface ccip_req_mux_if #(
  parameter int N_CH    = 4,
  parameter int HDR_W   = 64,
  parameter int MDATA_W = 16,
  parameter int RSP_W   = 512
);
  logic [N_CH-1:0]         ch_req_valid;
  logic [N_CH*HDR_W-1:0]   ch_req_hdr;
  logic [N_CH*MDATA_W-1:0] ch_req_mdata;
  logic [N_CH-1:0]         ch_req_almfull;
  logic                    out_req_valid;
  logic [HDR_W-1:0]        out_req_hdr;
  logic [MDATA_W-1:0]      out_req_mdata;
  logic                    out_almfull;
  logic                    rsp_in_valid;
  logic [MDATA_W-1:0]      rsp_in_mdata;
  logic [RSP_W-1:0]        rsp_in_data;
  logic [N_CH-1:0]         ch_rsp_valid;
  logic [MDATA_W-1:0]      ch_rsp_mdata;
  logic [RSP_W-1:0]        ch_rsp_data;
  logic [N_CH-1:0]         err_overflow;
  logic                    err_bad_tag;

  modport master (
    output ch_req_valid, ch_req_hdr, ch_req_mdata, out_almfull,
           rsp_in_valid, rsp_in_mdata, rsp_in_data,
    input  ch_req_almfull, out_req_valid, out_req_hdr, out_req_mdata,
           ch_rsp_valid, ch_rsp_mdata, ch_rsp_data, err_overflow, err_bad_tag
  );

  modport slave (
    input  ch_req_valid, ch_req_hdr, ch_req_mdata, out_almfull,
           rsp_in_valid, rsp_in_mdata, rsp_in_data,
    output ch_req_almfull, out_req_valid, out_req_hdr, out_req_mdata,
           ch_rsp_valid, ch_rsp_mdata, ch_rsp_data, err_overflow, err_bad_tag
  );
endinterface

// File: rtl/ccip_req_mux.sv
// N-channel CCI-P request mux: per-channel FIFOs, round-robin merge with the
// channel ID in the top mdata bits, and tag-steered response demux.
module ccip_req_mux #(
  parameter int N_CH          = 4,
  parameter int HDR_W         = 64,
  parameter int MDATA_W       = 16,
  parameter int RSP_W         = 512,
  parameter int FIFO_DEPTH    = 8,
  parameter int ALMFULL_SLACK = 2
) (
  input logic           pClk,
  input logic           pReset_n,
  ccip_req_mux_if.slave bus
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int LO_W  = MDATA_W - CH_W;
  localparam int ENT_W = HDR_W + LO_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] ALMFULL_THR = CNT_W'(FIFO_DEPTH - ALMFULL_SLACK);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);

  logic [ENT_W-1:0]       headEntry [N_CH];
  logic [ENT_W-1:0]       popEntry;
  logic [N_CH-1:0]        notEmpty;
  logic [N_CH-1:0]        popCh;
  logic [N_CH-1:0]        chAlmfull;
  logic [N_CH-1:0]        chOverflow;
  logic [N_CH*CH_W-1:0]   unusedMdataTop;
  logic                   almfullQ;
  logic [CH_W-1:0]        rrPtr;
  logic [CH_W-1:0]        grantCh;
  logic [CH_W-1:0]        searchIdx;
  logic                   grantValid;

  for (genvar g = 0; g < N_CH; g++) begin : gCh
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             wrEn;
    logic             almFull;
    logic             ovf;

    // A full FIFO still accepts a write in the same cycle it is popped.
    assign full = (count == FULL_CNT);
    assign wrEn = bus.ch_req_valid[g] && (!full || popCh[g]);

    always_ff @(posedge pClk) begin
      if (wrEn) begin
        mem[wrPtr] <= {bus.ch_req_hdr[g*HDR_W +: HDR_W], bus.ch_req_mdata[g*MDATA_W +: LO_W]};
      end
    end

    always_ff @(posedge pClk or negedge pReset_n) begin
      if (!pReset_n) begin
        wrPtr   <= '0;
        rdPtr   <= '0;
        count   <= '0;
        almFull <= 1'b0;
        ovf     <= 1'b0;
      end else begin
        if (wrEn) wrPtr <= wrPtr + 1'b1;
        if (popCh[g]) rdPtr <= rdPtr + 1'b1;
        case ({wrEn, popCh[g]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        almFull <= (count >= ALMFULL_THR);
        if (bus.ch_req_valid[g] && !wrEn) ovf <= 1'b1;
      end
    end

    assign notEmpty[g]   = (count != '0);
    assign headEntry[g]  = mem[rdPtr];
    assign chAlmfull[g]  = almFull;
    assign chOverflow[g] = ovf;
    assign unusedMdataTop[g*CH_W +: CH_W] = bus.ch_req_mdata[g*MDATA_W + LO_W +: CH_W];
  end

  assign bus.ch_req_almfull = chAlmfull;
  assign bus.err_overflow   = chOverflow;

  // First non-empty channel at or after rrPtr, wrapping at N_CH.
  always_comb begin
    grantValid = 1'b0;
    grantCh    = '0;
    searchIdx  = '0;
    for (int i = 0; i < N_CH; i++) begin
      searchIdx = CH_W'((int'(rrPtr) + i) % N_CH);
      if (!grantValid && !almfullQ && notEmpty[searchIdx]) begin
        grantValid = 1'b1;
        grantCh    = searchIdx;
      end
    end
  end

  always_comb begin
    popCh = '0;
    if (grantValid) popCh[grantCh] = 1'b1;
  end

  assign popEntry = headEntry[grantCh];

  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) begin
      almfullQ          <= 1'b0;
      rrPtr             <= '0;
      bus.out_req_valid <= 1'b0;
      bus.out_req_hdr   <= '0;
      bus.out_req_mdata <= '0;
    end else begin
      almfullQ          <= bus.out_almfull;
      bus.out_req_valid <= grantValid;
      if (grantValid) begin
        bus.out_req_hdr   <= popEntry[ENT_W-1 -: HDR_W];
        bus.out_req_mdata <= {grantCh, popEntry[LO_W-1:0]};
        rrPtr             <= (grantCh == CH_W'(N_CH - 1)) ? '0 : grantCh + 1'b1;
      end
    end
  end

  logic [CH_W-1:0] rspTag;
  logic [N_CH-1:0] rspOneHot;
  logic            rspTagOk;

  assign rspTag = bus.rsp_in_mdata[MDATA_W-1 -: CH_W];

  // A tag matching no channel yields an all-zero one-hot and is dropped.
  always_comb begin
    rspOneHot = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rspTag == CH_W'(i)) rspOneHot[i] = 1'b1;
    end
  end

  assign rspTagOk = |rspOneHot;

  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) begin
      bus.ch_rsp_valid <= '0;
      bus.ch_rsp_mdata <= '0;
      bus.ch_rsp_data  <= '0;
      bus.err_bad_tag  <= 1'b0;
    end else begin
      bus.ch_rsp_valid <= bus.rsp_in_valid ? rspOneHot : '0;
      if (bus.rsp_in_valid && rspTagOk) begin
        bus.ch_rsp_mdata <= {{CH_W{1'b0}}, bus.rsp_in_mdata[LO_W-1:0]};
        bus.ch_rsp_data  <= bus.rsp_in_data;
      end
      if (bus.rsp_in_valid && !rspTagOk) bus.err_bad_tag <= 1'b1;
    end
  end
endmodule
